hazard_ctrl: RTL and testbench
==============================

// Module: hazard_ctrl
// PURPOSE
//  Parametrised pipeline hazard controller for the 5-stage MIPS core (F/D/E/M/W).
//  Operand-forwarding selects for E and for D-stage branch compare; load-use and
//  branch-use interlocks; multi-cycle E-stage op timer (mul/div) with FSM; redirect flush.
//  Drives stall/flush enables of all pipeline registers.
// PARAMETERS
//  NREG    32  architectural registers; address width AW = $clog2(NREG); reg 0 never forwarded/interlocked
//  MC_LAT  8   cycles a multi-cycle op occupies E (>=1)
//  CW      32  perf-counter width (only with HAZARD_PERF_EN)
// PORTS
//  clk          in   1    core clock
//  resetn       in   1    synchronous active-low reset
//  rs_D, rt_D   in   AW   D-stage source regs
//  branch_D     in   1    D instr compares rs/rt (beq/bne)
//  rs_E, rt_E   in   AW   E-stage source regs
//  write_reg_E/M/W in AW  destination per stage
//  reg_write_E/M/W in 1   destination valid per stage
//  mem_to_reg_E/M  in 1   stage holds a load
//  mc_start_E   in   1    E holds multi-cycle op
//  redirect_D   in   1    taken branch/jump resolved in D
//  hazard       out  hazard_ctrl_t  {fwd_a_E,fwd_b_E:fwd_sel_e; fwd_a_D,fwd_b_D:1; stall_F,stall_D,stall_E,flush_D,flush_E,flush_M:1}
//  mc_busy      out  1    FSM in MC_BUSY or start cycle
//  mc_done      out  1    one-cycle pulse, E result releases
// BEHAVIOUR
//  Reset (resetn=0 at posedge): state<=IDLE, cnt<=0; while resetn=0 all outputs forced 0.
//  Forward E (per operand, src!=0): M match, reg_write_M, !mem_to_reg_M -> FWD_M(2'b10);
//   else W match, reg_write_W -> FWD_W(2'b01); else FWD_NONE. rs and rt independent (both may forward).
//  Forward D: fwd_x_D=1 iff branch_D, src!=0, reg_write_M, !mem_to_reg_M, write_reg_M==src.
//  Load-use: mem_to_reg_E & reg_write_E & write_reg_E!=0 & (==rs_D | ==rt_D) -> stall_F,stall_D,flush_E.
//  Branch-use: branch_D & ((reg_write_E & dest_E match) | (mem_to_reg_M & dest_M match)) -> same as load-use.
//  FSM IDLE/MC_BUSY/MC_DONE, cnt width $clog2(MC_LAT+1):
//   IDLE: mc_start_E -> stall_F/D/E=1, flush_M=1; MC_LAT==1 -> MC_DONE, else cnt<=MC_LAT-1, MC_BUSY.
//   MC_BUSY: stall_F/D/E, flush_M=1; cnt--; at cnt==1 -> MC_DONE.
//   MC_DONE: no MC stall, mc_done=1, mc_start_E ignored this cycle; -> IDLE.
//   Stall exactly MC_LAT cycles (start cycle t .. t+MC_LAT-1); E advances at t+MC_LAT.
//  Priority: MC stall > load/branch-use (during MC stall flush_E=0, stall_D=1 holds D).
//  redirect_D: flush_D=1 unless stall_D=1 (stall wins; redirect re-asserted by held D instr).
//  Reset mid-op: FSM to IDLE next edge, no mc_done pulse.
// CONFIGURATION
//  HAZARD_PERF_EN defined: extra outputs perf_stall_cyc, perf_lu_cnt, perf_mc_cnt (CW each),
//   incrementing on stall_F, load/branch-use event, IDLE->MC start; saturate at all-ones; reset 0.
//  Undefined: ports and counters absent; all other behaviour identical.
// STRUCTURE
//  pipes package: fwd_sel_e {FWD_NONE=2'b00,FWD_W=2'b01,FWD_M=2'b10}, hazard_ctrl_t, mc_state_e.
//  Sub-module hazard_mc_timer: FSM + cnt, outputs mc_stall, mc_busy, mc_done.
//  Top: combinational forward/interlock logic, priority merge, optional perf counters.
// TESTING
//  rs_E=5, M writes 5 (ALU), W writes 5 -> fwd_a_E=FWD_M; rt_E=5 same cycle -> fwd_b_E=FWD_M.
//  E lw $8, rt_D=8 -> stall_F,stall_D,flush_E=1 one cycle; next cycle fwd_b_E=FWD_W path clean.
//  mc_start_E at cycle 10, MC_LAT=8 -> stalls cycles 10..17, mc_done at 18, no restart at 18.
//  resetn=0 at cycle 13 mid-MC -> outputs 0, cycle 14 IDLE, no mc_done.
//  write_reg_M=0, reg_write_M=1, rs_E=0 -> fwd_a_E=FWD_NONE; branch_D with E dest=rs_D -> 1-cycle stall.
//  HAZARD_PERF_EN: two load-use + one 8-cycle MC -> perf_lu_cnt=2, perf_mc_cnt=1, perf_stall_cyc=10.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// Shared types for the 5-stage pipeline hazard controller: forwarding selects,
// the packed control bundle and the multi-cycle timer states.
package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    FWD_NONE = 2'b00,
    FWD_W    = 2'b01,
    FWD_M    = 2'b10
  } fwd_sel_e;

  typedef struct packed {
    fwd_sel_e fwd_a_E;
    fwd_sel_e fwd_b_E;
    logic     fwd_a_D;
    logic     fwd_b_D;
    logic     stall_F;
    logic     stall_D;
    logic     stall_E;
    logic     flush_D;
    logic     flush_E;
    logic     flush_M;
  } hazard_ctrl_t;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    MC_BUSY = 2'b01,
    MC_DONE = 2'b10
  } mc_state_e;

endpackage

// File: rtl/hazard_mc_timer.sv
// Occupancy timer for multi-cycle E-stage ops (mul/div): holds the pipe for
// exactly MC_LAT cycles starting with the start cycle, then pulses done.
module hazard_mc_timer
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned MC_LAT = 8
) (
  input  logic clk,
  input  logic resetn,
  input  logic start_i,
  output logic mc_stall_o,
  output logic mc_busy_o,
  output logic mc_done_o
);

  localparam int unsigned CNT_W = $clog2(MC_LAT + 1);

  mc_state_e        state_q;
  logic [CNT_W-1:0] cnt_q;

  // cnt holds the stall cycles still owed after the current one
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            if (MC_LAT == 1) begin
              state_q <= MC_DONE;
            end else begin
              cnt_q   <= CNT_W'(MC_LAT - 1);
              state_q <= MC_BUSY;
            end
          end
        end
        MC_BUSY: begin
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_q <= MC_DONE;
        end
        MC_DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // start cycle already stalls, so the op's first stall is not delayed a cycle
  assign mc_stall_o = resetn & (((state_q == IDLE) & start_i) | (state_q == MC_BUSY));
  assign mc_busy_o  = mc_stall_o;
  assign mc_done_o  = resetn & (state_q == MC_DONE);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: E/D forwarding, load-use and branch-use interlocks,
// multi-cycle op stall and redirect flush. Optional perf counters: HAZARD_PERF_EN.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned NREG   = 32,
  parameter int unsigned MC_LAT = 8
`ifdef HAZARD_PERF_EN
  , parameter int unsigned CW   = 32
`endif
  , localparam int unsigned AW  = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic [AW-1:0] rs_D,
  input  logic [AW-1:0] rt_D,
  input  logic          branch_D,
  input  logic [AW-1:0] rs_E,
  input  logic [AW-1:0] rt_E,
  input  logic [AW-1:0] write_reg_E,
  input  logic [AW-1:0] write_reg_M,
  input  logic [AW-1:0] write_reg_W,
  input  logic          reg_write_E,
  input  logic          reg_write_M,
  input  logic          reg_write_W,
  input  logic          mem_to_reg_E,
  input  logic          mem_to_reg_M,
  input  logic          mc_start_E,
  input  logic          redirect_D,
  output hazard_ctrl_t  hazard,
  output logic          mc_busy,
  output logic          mc_done
`ifdef HAZARD_PERF_EN
  , output logic [CW-1:0] perf_stall_cyc
  , output logic [CW-1:0] perf_lu_cnt
  , output logic [CW-1:0] perf_mc_cnt
`endif
);

  logic         mc_stall;
  logic         m_alu;
  logic         e_dst_hit;
  logic         m_dst_hit;
  logic         lu_hit;
  logic         bu_hit;
  logic         use_stall;
  hazard_ctrl_t hz_c;

  hazard_mc_timer #(.MC_LAT(MC_LAT)) u_mc_timer (
    .clk        (clk),
    .resetn     (resetn),
    .start_i    (mc_start_E),
    .mc_stall_o (mc_stall),
    .mc_busy_o  (mc_busy),
    .mc_done_o  (mc_done)
  );

  // $0 is hardwired, so a zero destination never matches a source
  function automatic logic dst_hit(input logic [AW-1:0] dst, input logic [AW-1:0] src);
    return (dst != '0) && (dst == src);
  endfunction

  function automatic fwd_sel_e fwd_e(input logic [AW-1:0] src);
    if (src == '0) return FWD_NONE;
    if (reg_write_M && !mem_to_reg_M && (write_reg_M == src)) return FWD_M;
    if (reg_write_W && (write_reg_W == src)) return FWD_W;
    return FWD_NONE;
  endfunction

  assign m_alu     = reg_write_M & ~mem_to_reg_M;
  assign e_dst_hit = reg_write_E & (dst_hit(write_reg_E, rs_D) | dst_hit(write_reg_E, rt_D));
  assign m_dst_hit = mem_to_reg_M & (dst_hit(write_reg_M, rs_D) | dst_hit(write_reg_M, rt_D));
  assign lu_hit    = mem_to_reg_E & e_dst_hit;
  assign bu_hit    = branch_D & (e_dst_hit | m_dst_hit);
  assign use_stall = lu_hit | bu_hit;

  // Merge: MC stall freezes F/D/E and bubbles M; otherwise interlocks bubble E
  always_comb begin
    hz_c = '0;
    if (resetn) begin
      hz_c.fwd_a_E = fwd_e(rs_E);
      hz_c.fwd_b_E = fwd_e(rt_E);
      hz_c.fwd_a_D = branch_D & m_alu & dst_hit(write_reg_M, rs_D);
      hz_c.fwd_b_D = branch_D & m_alu & dst_hit(write_reg_M, rt_D);
      if (mc_stall) begin
        hz_c.stall_F = 1'b1;
        hz_c.stall_D = 1'b1;
        hz_c.stall_E = 1'b1;
        hz_c.flush_M = 1'b1;
      end else if (use_stall) begin
        hz_c.stall_F = 1'b1;
        hz_c.stall_D = 1'b1;
        hz_c.flush_E = 1'b1;
      end
      hz_c.flush_D = redirect_D & ~hz_c.stall_D;
    end
  end

  assign hazard = hz_c;

`ifdef HAZARD_PERF_EN
  logic [CW-1:0] stall_cyc_q, stall_cyc_d;
  logic [CW-1:0] lu_cnt_q, lu_cnt_d;
  logic [CW-1:0] mc_cnt_q, mc_cnt_d;
  logic          mc_stall_prev_q;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v, input logic en);
    return (en && (v != '1)) ? v + CW'(1) : v;
  endfunction

  // Every op ends in a non-stalling done cycle, so a rising mc_stall marks a start
  always_comb begin
    stall_cyc_d = sat_inc(stall_cyc_q, hz_c.stall_F);
    lu_cnt_d    = sat_inc(lu_cnt_q, resetn & use_stall & ~mc_stall);
    mc_cnt_d    = sat_inc(mc_cnt_q, mc_stall & ~mc_stall_prev_q);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      stall_cyc_q     <= '0;
      lu_cnt_q        <= '0;
      mc_cnt_q        <= '0;
      mc_stall_prev_q <= 1'b0;
    end else begin
      stall_cyc_q     <= stall_cyc_d;
      lu_cnt_q        <= lu_cnt_d;
      mc_cnt_q        <= mc_cnt_d;
      mc_stall_prev_q <= mc_stall;
    end
  end

  assign perf_stall_cyc = resetn ? stall_cyc_q : '0;
  assign perf_lu_cnt    = resetn ? lu_cnt_q    : '0;
  assign perf_mc_cnt    = resetn ? mc_cnt_q    : '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: vector table plus multi-cycle sequences,
// expected results queued at drive time and checked on the falling edge.
module tb_hazard_ctrl;
  import hazard_ctrl_pkg::*;

  localparam int unsigned NREG   = 32;
  localparam int unsigned MC_LAT = 8;
  localparam int unsigned AW     = 5;

  // bits: {fwd_a_D, fwd_b_D, stall_F, stall_D, stall_E, flush_D, flush_E, flush_M}
  localparam logic [7:0] B_0   = 8'b0000_0000;
  localparam logic [7:0] B_LU  = 8'b0011_0010;
  localparam logic [7:0] B_MC  = 8'b0011_1001;
  localparam logic [7:0] B_FD  = 8'b0000_0100;
  localparam logic [7:0] B_FAD = 8'b1000_0000;
  localparam logic [7:0] B_FBD = 8'b0100_0000;

  typedef struct packed {
    logic          resetn;
    logic [AW-1:0] rs_D, rt_D;
    logic          branch_D;
    logic [AW-1:0] rs_E, rt_E;
    logic [AW-1:0] wr_E, wr_M, wr_W;
    logic          rw_E, rw_M, rw_W;
    logic          m2r_E, m2r_M;
    logic          mc_start;
    logic          redirect;
  } in_t;

  typedef struct {
    in_t          in;
    hazard_ctrl_t hz;
    string        name;
  } vec_t;

  typedef struct {
    hazard_ctrl_t hz;
    logic         busy;
    logic         done;
    string        name;
  } exp_t;

  logic          clk = 1'b0;
  logic          resetn;
  logic [AW-1:0] rs_D, rt_D, rs_E, rt_E, write_reg_E, write_reg_M, write_reg_W;
  logic          branch_D, reg_write_E, reg_write_M, reg_write_W;
  logic          mem_to_reg_E, mem_to_reg_M, mc_start_E, redirect_D;
  hazard_ctrl_t  hazard;
  logic          mc_busy, mc_done;
`ifdef HAZARD_PERF_EN
  logic [31:0]   perf_stall_cyc, perf_lu_cnt, perf_mc_cnt;
`endif

  exp_t sb_q[$];
  vec_t tbl[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  hazard_ctrl #(.NREG(NREG), .MC_LAT(MC_LAT)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .rs_D         (rs_D),
    .rt_D         (rt_D),
    .branch_D     (branch_D),
    .rs_E         (rs_E),
    .rt_E         (rt_E),
    .write_reg_E  (write_reg_E),
    .write_reg_M  (write_reg_M),
    .write_reg_W  (write_reg_W),
    .reg_write_E  (reg_write_E),
    .reg_write_M  (reg_write_M),
    .reg_write_W  (reg_write_W),
    .mem_to_reg_E (mem_to_reg_E),
    .mem_to_reg_M (mem_to_reg_M),
    .mc_start_E   (mc_start_E),
    .redirect_D   (redirect_D),
    .hazard       (hazard),
    .mc_busy      (mc_busy),
    .mc_done      (mc_done)
`ifdef HAZARD_PERF_EN
    , .perf_stall_cyc (perf_stall_cyc)
    , .perf_lu_cnt    (perf_lu_cnt)
    , .perf_mc_cnt    (perf_mc_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic in_t nop();
    in_t v = '0;
    v.resetn = 1'b1;
    return v;
  endfunction

  function automatic in_t lu_in(input in_t b);
    in_t v = b;
    v.m2r_E = 1'b1; v.rw_E = 1'b1; v.wr_E = 5'd8; v.rt_D = 5'd8;
    return v;
  endfunction

  function automatic hazard_ctrl_t hzf(input fwd_sel_e a, input fwd_sel_e b, input logic [7:0] bits);
    hazard_ctrl_t h;
    h = {a, b, bits};
    return h;
  endfunction

  function automatic void add(input in_t v, input hazard_ctrl_t h, input string nm);
    vec_t t;
    t.in = v; t.hz = h; t.name = nm;
    tbl.push_back(t);
  endfunction

  task automatic drive(input in_t v, input hazard_ctrl_t h, input logic busy, input logic done, input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    resetn = v.resetn; rs_D = v.rs_D; rt_D = v.rt_D; branch_D = v.branch_D;
    rs_E = v.rs_E; rt_E = v.rt_E;
    write_reg_E = v.wr_E; write_reg_M = v.wr_M; write_reg_W = v.wr_W;
    reg_write_E = v.rw_E; reg_write_M = v.rw_M; reg_write_W = v.rw_W;
    mem_to_reg_E = v.m2r_E; mem_to_reg_M = v.m2r_M;
    mc_start_E = v.mc_start; redirect_D = v.redirect;
    e.hz = h; e.busy = busy; e.done = done; e.name = nm;
    sb_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      n_chk++;
      if (hazard === e.hz && mc_busy === e.busy && mc_done === e.done) n_pass++;
      else $display("FAIL %s: got hazard=%h busy=%b done=%b, want hazard=%h busy=%b done=%b",
                    e.name, hazard, mc_busy, mc_done, e.hz, e.busy, e.done);
    end
  end

`ifdef HAZARD_PERF_EN
  task automatic chk_val(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0d want %0d", nm, got, want);
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    in_t v;
    in_t w;
    v = '0;
    resetn = 1'b0; rs_D = '0; rt_D = '0; branch_D = 1'b0; rs_E = '0; rt_E = '0;
    write_reg_E = '0; write_reg_M = '0; write_reg_W = '0;
    reg_write_E = 1'b0; reg_write_M = 1'b0; reg_write_W = 1'b0;
    mem_to_reg_E = 1'b0; mem_to_reg_M = 1'b0; mc_start_E = 1'b0; redirect_D = 1'b0;

    // Single-cycle combinational vectors
    v = '0; add(v, hzf(FWD_NONE, FWD_NONE, B_0), "reset_idle");
    v = lu_in(nop()); v.resetn = 1'b0; v.mc_start = 1'b1; v.redirect = 1'b1;
    add(v, hzf(FWD_NONE, FWD_NONE, B_0), "reset_forces_zero");
    v = nop(); v.rs_E = 5; v.rt_E = 5; v.wr_M = 5; v.rw_M = 1; v.wr_W = 5; v.rw_W = 1;
    add(v, hzf(FWD_M, FWD_M, B_0), "fwd_m_over_w");
    v = nop(); v.rs_E = 5; v.rt_E = 7; v.wr_M = 5; v.rw_M = 1; v.m2r_M = 1; v.wr_W = 5; v.rw_W = 1;
    add(v, hzf(FWD_W, FWD_NONE, B_0), "fwd_load_in_m_uses_w");
    v = nop(); v.rs_E = 3; v.rt_E = 4; v.wr_M = 4; v.rw_M = 1; v.wr_W = 3; v.rw_W = 1;
    add(v, hzf(FWD_W, FWD_M, B_0), "fwd_split_w_m");
    v = nop(); v.rs_E = 0; v.rt_E = 0; v.wr_M = 0; v.rw_M = 1; v.wr_W = 0; v.rw_W = 1;
    add(v, hzf(FWD_NONE, FWD_NONE, B_0), "fwd_reg0_never");
    v = nop(); v.rs_E = 9; v.rt_E = 9; v.wr_M = 9; v.rw_M = 0; v.wr_W = 9; v.rw_W = 1;
    add(v, hzf(FWD_W, FWD_W, B_0), "fwd_m_no_write");
    v = nop(); v.rs_E = 9; v.wr_W = 9; v.rw_W = 0;
    add(v, hzf(FWD_NONE, FWD_NONE, B_0), "fwd_w_no_write");
    v = lu_in(nop());
    add(v, hzf(FWD_NONE, FWD_NONE, B_LU), "load_use_rt");
    v = lu_in(nop()); v.rt_D = 0; v.rs_D = 8; v.redirect = 1;
    add(v, hzf(FWD_NONE, FWD_NONE, B_LU), "load_use_rs_blocks_redirect");
    v = nop(); v.redirect = 1;
    add(v, hzf(FWD_NONE, FWD_NONE, B_FD), "redirect_flush_d");
    v = nop(); v.m2r_E = 1; v.rw_E = 1; v.wr_E = 0; v.rs_D = 0;
    add(v, hzf(FWD_NONE, FWD_NONE, B_0), "load_reg0_no_stall");
    v = lu_in(nop()); v.rw_E = 0;
    add(v, hzf(FWD_NONE, FWD_NONE, B_0), "load_no_write_no_stall");
    v = nop(); v.branch_D = 1; v.rs_D = 9; v.rw_E = 1; v.wr_E = 9;
    add(v, hzf(FWD_NONE, FWD_NONE, B_LU), "branch_use_e_alu");
    v = nop(); v.rs_D = 9; v.rw_E = 1; v.wr_E = 9;
    add(v, hzf(FWD_NONE, FWD_NONE, B_0), "alu_e_no_branch_no_stall");
    v = nop(); v.branch_D = 1; v.rt_D = 6; v.wr_M = 6; v.rw_M = 1; v.m2r_M = 1;
    add(v, hzf(FWD_NONE, FWD_NONE, B_LU), "branch_use_m_load");
    v = nop(); v.branch_D = 1; v.rs_D = 6; v.rt_D = 6; v.wr_M = 6; v.rw_M = 1;
    add(v, hzf(FWD_NONE, FWD_NONE, B_FAD | B_FBD), "fwd_d_both");
    v = nop(); v.branch_D = 1; v.rs_D = 6; v.rt_D = 2; v.wr_M = 6; v.rw_M = 1;
    add(v, hzf(FWD_NONE, FWD_NONE, B_FAD), "fwd_d_rs_only");
    v = nop(); v.rs_D = 6; v.wr_M = 6; v.rw_M = 1;
    add(v, hzf(FWD_NONE, FWD_NONE, B_0), "fwd_d_needs_branch");
    v = nop(); v.branch_D = 1; v.rs_D = 0; v.wr_M = 0; v.rw_M = 1; v.rw_E = 1; v.wr_E = 0;
    add(v, hzf(FWD_NONE, FWD_NONE, B_0), "branch_reg0_clean");

    foreach (tbl[i]) begin
      drive(tbl[i].in, tbl[i].hz, 1'b0, 1'b0, tbl[i].name);
    end

    // Load-use followed by the bubble and the W-forwarded consumer
    drive(lu_in(nop()), hzf(FWD_NONE, FWD_NONE, B_LU), 1'b0, 1'b0, "lu_seq_stall");
    v = nop(); v.rt_D = 8; v.wr_M = 8; v.rw_M = 1; v.m2r_M = 1;
    drive(v, hzf(FWD_NONE, FWD_NONE, B_0), 1'b0, 1'b0, "lu_seq_bubble");
    v = nop(); v.rt_E = 8; v.wr_W = 8; v.rw_W = 1;
    drive(v, hzf(FWD_NONE, FWD_W, B_0), 1'b0, 1'b0, "lu_seq_fwd_w");

    // Multi-cycle op: start held for the whole occupancy and the done cycle
    v = nop(); v.mc_start = 1;
    for (int i = 0; i < int'(MC_LAT); i++) begin
      w = v;
      if (i == 3) w = lu_in(v);
      if (i == 5) w.redirect = 1;
      drive(w, hzf(FWD_NONE, FWD_NONE, B_MC), 1'b1, 1'b0, "mc_stall");
    end
    drive(v, hzf(FWD_NONE, FWD_NONE, B_0), 1'b0, 1'b1, "mc_done_pulse");
    drive(nop(), hzf(FWD_NONE, FWD_NONE, B_0), 1'b0, 1'b0, "mc_no_restart");
    drive(nop(), hzf(FWD_NONE, FWD_NONE, B_0), 1'b0, 1'b0, "mc_idle_after");

    // Reset in the middle of an op: no done pulse afterwards
    for (int i = 0; i < 3; i++) drive(v, hzf(FWD_NONE, FWD_NONE, B_MC), 1'b1, 1'b0, "mc2_stall");
    w = v; w.resetn = 1'b0;
    drive(w, hzf(FWD_NONE, FWD_NONE, B_0), 1'b0, 1'b0, "mc2_reset_zero");
    for (int i = 0; i < 3; i++) drive(nop(), hzf(FWD_NONE, FWD_NONE, B_0), 1'b0, 1'b0, "mc2_after_reset");

    // Fresh op right after reset recovery completes normally
    for (int i = 0; i < int'(MC_LAT); i++) drive(v, hzf(FWD_NONE, FWD_NONE, B_MC), 1'b1, 1'b0, "mc3_stall");
    drive(nop(), hzf(FWD_NONE, FWD_NONE, B_0), 1'b0, 1'b1, "mc3_done");

`ifdef HAZARD_PERF_EN
    v = '0;
    drive(v, hzf(FWD_NONE, FWD_NONE, B_0), 1'b0, 1'b0, "perf_reset");
    drive(lu_in(nop()), hzf(FWD_NONE, FWD_NONE, B_LU), 1'b0, 1'b0, "perf_lu1");
    drive(nop(), hzf(FWD_NONE, FWD_NONE, B_0), 1'b0, 1'b0, "perf_gap");
    drive(lu_in(nop()), hzf(FWD_NONE, FWD_NONE, B_LU), 1'b0, 1'b0, "perf_lu2");
    v = nop(); v.mc_start = 1;
    for (int i = 0; i < int'(MC_LAT); i++) drive(v, hzf(FWD_NONE, FWD_NONE, B_MC), 1'b1, 1'b0, "perf_mc");
    drive(nop(), hzf(FWD_NONE, FWD_NONE, B_0), 1'b0, 1'b1, "perf_mc_done");
    drive(nop(), hzf(FWD_NONE, FWD_NONE, B_0), 1'b0, 1'b0, "perf_idle");
    @(negedge clk);
    #1;
    chk_val("perf_stall_cyc", perf_stall_cyc, 32'd10);
    chk_val("perf_lu_cnt", perf_lu_cnt, 32'd2);
    chk_val("perf_mc_cnt", perf_mc_cnt, 32'd1);
`endif

    for (int k = 0; k < 10 && sb_q.size() > 0; k++) @(negedge clk);
    #1;
    if (sb_q.size() > 0) begin
      n_chk++;
      $display("FAIL drain: got %0d pending want 0", sb_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
